// File: rtl/approx_mult8_pkg.sv
// approx_mult8_pkg
//   Shared widths and defaults for the approximate 8x8 multiplier.
//   IN_W            operand width
//   SUM_W           full product width (exact 8x8 product fits here)
//   OUT_W           saturated output width
//   OUT_MAX         saturation ceiling
//   APPROX_COLS_DEF default number of OR-reduced low-order columns
package approx_mult8_pkg;

    localparam int             IN_W            = 8;
    localparam int             SUM_W           = 2 * IN_W;
    localparam int             OUT_W           = 15;
    localparam logic [OUT_W-1:0] OUT_MAX       = 15'h7FFF;
    localparam int             APPROX_COLS_DEF = 6;

endpackage : approx_mult8_pkg

// File: rtl/approx_mult8_core.sv
// approx_mult8_core
//   Purely combinational approximate unsigned multiplier.
//   Partial-product columns below APPROX_COLS are ORed (no carries generated),
//   the remaining columns are summed exactly, and the result saturates to OUT_MAX.
// Ports:
//   num1  in  [IN_W-1:0]   operand A
//   num2  in  [IN_W-1:0]   operand B
//   prod  out [OUT_W-1:0]  approximate product, saturated
import approx_mult8_pkg::*;

module approx_mult8_core #(
    parameter int APPROX_COLS = APPROX_COLS_DEF
) (
    input  logic [IN_W-1:0]  num1,
    input  logic [IN_W-1:0]  num2,
    output logic [OUT_W-1:0] prod
);

    // Bits at or above APPROX_COLS belong to the exact (high) part.
    localparam logic [SUM_W-1:0] HI_MASK = {SUM_W{1'b1}} << APPROX_COLS;

    // Running sum of the high part and running OR of the low part, one step
    // per partial-product row. Separate unpacked elements keep each stage an
    // independent net.
    logic [SUM_W-1:0] acc_hi [IN_W+1];
    logic [SUM_W-1:0] acc_lo [IN_W+1];
    logic [SUM_W-1:0] approx;

    assign acc_hi[0] = '0;
    assign acc_lo[0] = '0;

    for (genvar r = 0; r < IN_W; r++) begin : g_row
        logic [SUM_W-1:0] row;

        // Row r holds pp[r][j] = num1[j] & num2[r] placed at weight r+j.
        assign row = {{(SUM_W-IN_W){1'b0}}, num1 & {IN_W{num2[r]}}} << r;

        assign acc_hi[r+1] = acc_hi[r] + (row & HI_MASK);
        // ORing whole rows at the same weights is the per-column OR.
        assign acc_lo[r+1] = acc_lo[r] | (row & ~HI_MASK);
    end

    // High part is a multiple of 2**APPROX_COLS, so OR merges without overlap.
    assign approx = acc_hi[IN_W] | acc_lo[IN_W];

    assign prod = (approx > {1'b0, OUT_MAX}) ? OUT_MAX : approx[OUT_W-1:0];

endmodule : approx_mult8_core

// File: rtl/approx_mult8.sv
// approx_mult8
//   Registered 8x8 unsigned approximate multiplier, 1-cycle latency,
//   one operand pair accepted per cycle, no backpressure.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid this cycle
//   num1       in   [7:0]  operand A
//   num2       in   [7:0]  operand B
//   out_valid  out  prod holds a result from the previous cycle
//   prod       out  [14:0] approximate product, saturated; held when idle
import approx_mult8_pkg::*;

module approx_mult8 #(
    parameter int APPROX_COLS = APPROX_COLS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  num1,
    input  logic [IN_W-1:0]  num2,
    output logic             out_valid,
    output logic [OUT_W-1:0] prod
);

    logic [OUT_W-1:0] prod_next;

    approx_mult8_core #(
        .APPROX_COLS (APPROX_COLS)
    ) u_core (
        .num1 (num1),
        .num2 (num2),
        .prod (prod_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            prod      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                prod <= prod_next;
            end
        end
    end

endmodule : approx_mult8

// File: tb/tb_approx_mult8.sv
// tb_approx_mult8
//   Directed and exhaustive checks of approx_mult8 with the default column
//   count and with APPROX_COLS=0 (exact, saturated).
module tb_approx_mult8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  num1;
    logic [7:0]  num2;
    logic        out_valid;
    logic [14:0] prod;
    logic        out_valid_x;
    logic [14:0] prod_x;

    int n_cmp = 0;
    int n_mis = 0;

    approx_mult8 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .prod      (prod)
    );

    approx_mult8 #(
        .APPROX_COLS (0)
    ) u_dut_exact (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid_x),
        .prod      (prod_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Column-by-column reference: count bits per weight, OR the low columns,
    // add count<<w for the rest.
    function automatic int golden(input int a, input int b, input int cols);
        int r;
        int cnt;
        int j;
        r = 0;
        for (int w = 0; w < 15; w++) begin
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                j = w - i;
                if (j >= 0 && j < 8) cnt += ((a >> j) & 1) & ((b >> i) & 1);
            end
            if (w < cols) begin
                if (cnt != 0) r |= (1 << w);
            end else begin
                r += cnt << w;
            end
        end
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > 32767) ? 32767 : v;
    endfunction

    // Directed vectors: operands, expected default-instance result,
    // expected exact-instance result (all hand-computed).
    int va  [7] = '{7,  3, 100,  16,   0,   200,   255};
    int vb  [7] = '{7,  3,  50,   8, 255,   200,   255};
    int ve  [7] = '{31, 7, 5000, 128,  0, 32767, 32767};
    int vex [7] = '{49, 9, 5000, 128,  0, 32767, 32767};

    int bit_err [16];
    int le_viol;
    int exact_p;
    int diff;

    task automatic drive(input logic v, input int a, input int b);
        @(negedge clk);
        in_valid = v;
        num1     = 8'(a);
        num2     = 8'(b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        num1     = '0;
        num2     = '0;
        foreach (bit_err[b]) bit_err[b] = 0;
        le_viol = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset prod", prod, 0);
        chk("reset out_valid", out_valid, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle after release out_valid", out_valid, 0);

        for (int k = 0; k < 7; k++) begin
            drive(1'b1, va[k], vb[k]);
            chk($sformatf("dir %0dx%0d", va[k], vb[k]), prod, ve[k]);
            chk($sformatf("dir_exact %0dx%0d", va[k], vb[k]), prod_x, vex[k]);
            chk($sformatf("dir valid %0dx%0d", va[k], vb[k]), out_valid, 1);
        end
        drive(1'b1, 181, 181);
        chk("exact 181x181", prod_x, 32761);

        // Back-to-back, then a gap.
        drive(1'b1, 7, 7);
        chk("b2b0 prod", prod, 31);
        chk("b2b0 valid", out_valid, 1);
        drive(1'b1, 16, 8);
        chk("b2b1 prod", prod, 128);
        chk("b2b1 valid", out_valid, 1);
        drive(1'b1, 3, 3);
        chk("b2b2 prod", prod, 7);
        chk("b2b2 valid", out_valid, 1);
        drive(1'b0, 200, 200);
        chk("gap valid", out_valid, 0);
        chk("gap prod held", prod, 7);
        drive(1'b0, 255, 255);
        chk("gap2 prod held", prod, 7);

        // Asynchronous reset with a result present and another one pending.
        drive(1'b1, 100, 50);
        chk("pre-reset prod", prod, 5000);
        @(negedge clk);
        num1 = 8'd7;
        num2 = 8'd7;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset prod", prod, 0);
        chk("async reset valid", out_valid, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post-release valid", out_valid, 0);
        chk("post-release prod", prod, 0);

        // Exhaustive sweep, num1 >= num2 >= 1.
        for (int a = 1; a < 256; a++) begin
            for (int b = 1; b <= a; b++) begin
                drive(1'b1, a, b);
                exact_p = a * b;
                chk($sformatf("sweep %0dx%0d", a, b), prod, sat(golden(a, b, 6)));
                chk($sformatf("sweep_exact %0dx%0d", a, b), prod_x, sat(exact_p));
                if (int'(prod) > exact_p) le_viol++;
                diff = int'(prod) ^ exact_p;
                for (int bi = 0; bi < 16; bi++) begin
                    if (((diff >> bi) & 1) != 0) bit_err[bi]++;
                end
            end
        end
        chk("approx<=exact violations", le_viol, 0);

        for (int bi = 0; bi < 16; bi++) begin
            $display("bit %0d differs from exact product in %0d of 32640 pairs", bi, bit_err[bi]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_approx_mult8
